instr_decode: RTL and testbench

//  Decode stage of the 4-stage 8-bit pipeline; sits directly downstream of fetch.
//  - Registers each fetched instr (IF/ID).
//  - Holds an 8x8-bit register file.
//  - Resolves BZ branches, driving pc_src/jmp_rel_addr back to fetch.
//  - Flushes the wrong-path slot and presents operands to execute via the ID/EX register.

---
 rtl/instr_decode.sv | 101 ++++++++++
 tb/tb_instr_decode.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
// Decode stage: IF/ID register, 8x8 register file, BZ branch resolution and ID/EX register.
// Optional write-through register reads enabled by defining DECODE_BYPASS_EN.
module instr_decode #(
  parameter int NREG = 8,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    instr,
  input  logic          wb_en,
  input  logic [2:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          pc_src,
  output logic [5:0]    jmp_rel_addr,
  output logic          ex_valid,
  output logic [1:0]    ex_op,
  output logic [2:0]    ex_rd,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [7:0]    br_taken_cnt
);

  localparam logic [1:0] OP_ADDI = 2'b10;
  localparam logic [1:0] OP_BZ   = 2'b11;

  logic [DW-1:0] regs [NREG];
  logic [7:0]    id_instr_reg;
  logic          id_valid_reg;

  logic [1:0]    id_op;
  logic [2:0]    id_rd;
  logic [2:0]    id_rs;
  logic [DW-1:0] rd_val;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] r0_val;
  logic [DW-1:0] imm_ext;

  assign id_op   = id_instr_reg[7:6];
  assign id_rd   = id_instr_reg[5:3];
  assign id_rs   = id_instr_reg[2:0];
  assign imm_ext = {{(DW-3){id_instr_reg[2]}}, id_instr_reg[2:0]};

`ifdef DECODE_BYPASS_EN
  // Write-through: a register written this cycle is seen by decode immediately.
  assign rd_val = (wb_en && wb_addr == id_rd) ? wb_data : regs[id_rd];
  assign rs_val = (wb_en && wb_addr == id_rs) ? wb_data : regs[id_rs];
  assign r0_val = (wb_en && wb_addr == 3'd0)  ? wb_data : regs[0];
`else
  assign rd_val = regs[id_rd];
  assign rs_val = regs[id_rs];
  assign r0_val = regs[0];
`endif

  // id_valid is zero throughout reset, so no branch can be requested then.
  assign pc_src       = id_valid_reg && (id_op == OP_BZ) && (r0_val == '0);
  assign jmp_rel_addr = id_instr_reg[5:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // The slot fetched while a branch is taken is the wrong path and is squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_instr_reg <= '0;
      id_valid_reg <= 1'b0;
    end else begin
      id_instr_reg <= instr;
      id_valid_reg <= ~pc_src;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_taken_cnt <= '0;
    end else if (pc_src) begin
      br_taken_cnt <= br_taken_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !id_valid_reg || id_op == OP_BZ) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_rd    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
    end else begin
      ex_valid <= 1'b1;
      ex_op    <= id_op;
      ex_rd    <= id_rd;
      ex_a     <= rd_val;
      ex_b     <= (id_op == OP_ADDI) ? imm_ext : rs_val;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: directed spec scenarios plus random traffic against a behavioural model.
// Honours DECODE_BYPASS_EN the same way as the design.
module tb_instr_decode;

  logic       clk;
  logic       rst;
  logic [7:0] instr;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       pc_src;
  logic [5:0] jmp_rel_addr;
  logic       ex_valid;
  logic [1:0] ex_op;
  logic [2:0] ex_rd;
  logic [7:0] ex_a;
  logic [7:0] ex_b;
  logic [7:0] br_taken_cnt;

  instr_decode dut (
    .clk(clk), .rst(rst), .instr(instr), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .pc_src(pc_src), .jmp_rel_addr(jmp_rel_addr),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b),
    .br_taken_cnt(br_taken_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural registers plus the two pipeline slots.
  int m_r [8];
  int m_id_instr, m_id_valid;
  int m_ex_valid, m_ex_op, m_ex_rd, m_ex_a, m_ex_b, m_cnt;
  bit model_ready = 0;

  function automatic int exp_read(input int a);
    int v;
    v = m_r[a];
`ifdef DECODE_BYPASS_EN
    if (wb_en === 1'b1 && int'(wb_addr) == a) v = int'(wb_data);
`endif
    return v;
  endfunction

  function automatic int exp_pc();
    return (m_id_valid == 1 && (m_id_instr / 64) == 3 && exp_read(0) == 0) ? 1 : 0;
  endfunction

  initial begin
    int pc, op, rdi, rsi, imm;
    forever begin
      @(posedge clk);
      pc = exp_pc();
      if (rst) begin
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_id_instr = 0; m_id_valid = 0;
        m_ex_valid = 0; m_ex_op = 0; m_ex_rd = 0; m_ex_a = 0; m_ex_b = 0;
        m_cnt = 0;
      end else begin
        op  = m_id_instr / 64;
        rdi = (m_id_instr / 8) % 8;
        rsi = m_id_instr % 8;
        if (m_id_valid == 1 && op != 3) begin
          m_ex_valid = 1; m_ex_op = op; m_ex_rd = rdi;
          m_ex_a = exp_read(rdi);
          if (op == 2) begin
            imm = rsi;
            if (imm >= 4) imm = imm - 8;
            m_ex_b = (imm + 256) % 256;
          end else begin
            m_ex_b = exp_read(rsi);
          end
        end else begin
          m_ex_valid = 0; m_ex_op = 0; m_ex_rd = 0; m_ex_a = 0; m_ex_b = 0;
        end
        m_cnt = (m_cnt + pc) % 256;
        if (wb_en) m_r[wb_addr] = int'(wb_data);
        m_id_valid = (pc == 1) ? 0 : 1;
        m_id_instr = int'(instr);
      end
      model_ready = 1;
    end
  end

  // Per-cycle compare, mid-cycle after the inputs for this cycle have settled.
  initial begin
    int p;
    forever begin
      @(negedge clk);
      #1;
      if (model_ready) begin
        p = exp_pc();
        chk("pc_src", 32'(pc_src), 32'(p));
        if (p == 1) chk("jmp_rel_addr", 32'(jmp_rel_addr), 32'(m_id_instr % 64));
        chk("ex_valid", 32'(ex_valid), 32'(m_ex_valid));
        chk("ex_op", 32'(ex_op), 32'(m_ex_op));
        chk("ex_rd", 32'(ex_rd), 32'(m_ex_rd));
        chk("ex_a", 32'(ex_a), 32'(m_ex_a));
        chk("ex_b", 32'(ex_b), 32'(m_ex_b));
        chk("br_taken_cnt", 32'(br_taken_cnt), 32'(m_cnt));
      end
    end
  end

  task automatic drive(input logic [7:0] i, input logic we, input logic [2:0] a,
                       input logic [7:0] d, input logic r);
    @(negedge clk);
    instr = i; wb_en = we; wb_addr = a; wb_data = d; rst = r;
  endtask

  task automatic post();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int cnt_pre;
    rst = 1'b1; instr = 8'h80; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (3) @(posedge clk);

    // Reset release, first NOP
    drive(8'h80, 0, 0, 0, 0); post();
    chk("t1_ex_valid", 32'(ex_valid), 32'd0);
    chk("t1_pc_src", 32'(pc_src), 32'd0);
    chk("t1_cnt", 32'(br_taken_cnt), 32'd0);
    drive(8'h80, 0, 0, 0, 0); post();
    chk("t1_ex_valid_nop", 32'(ex_valid), 32'd1);
    chk("t1_ex_b", 32'(ex_b), 32'd0);

    // ADD r1,r2 after write-back of r1=5, r2=3
    drive(8'h80, 1, 1, 8'h05, 0); post();
    drive(8'h80, 1, 2, 8'h03, 0); post();
    drive(8'h0A, 0, 0, 0, 0); post();
    drive(8'h80, 0, 0, 0, 0); post();
    chk("t2_ex_op", 32'(ex_op), 32'd0);
    chk("t2_ex_rd", 32'(ex_rd), 32'd1);
    chk("t2_ex_a", 32'(ex_a), 32'd5);
    chk("t2_ex_b", 32'(ex_b), 32'd3);

    // ADDI r3,-1
    drive(8'h9F, 0, 0, 0, 0); post();
    drive(8'h80, 0, 0, 0, 0); post();
    chk("t3_ex_op", 32'(ex_op), 32'd2);
    chk("t3_ex_rd", 32'(ex_rd), 32'd3);
    chk("t3_ex_b", 32'(ex_b), 32'hFF);

    // Taken BZ with r0=0
    drive(8'hC4, 0, 0, 0, 0); post();
    chk("t4_pc_src", 32'(pc_src), 32'd1);
    chk("t4_jmp", 32'(jmp_rel_addr), 32'd4);
    drive(8'h88, 0, 0, 0, 0); post();
    chk("t4_cnt", 32'(br_taken_cnt), 32'd1);
    chk("t4_bz_ex_valid", 32'(ex_valid), 32'd0);
    chk("t4_flush_pc_src", 32'(pc_src), 32'd0);
    drive(8'h0A, 0, 0, 0, 0); post();
    chk("t4_bubble", 32'(ex_valid), 32'd0);
    drive(8'h80, 0, 0, 0, 0); post();
    chk("t4_after_valid", 32'(ex_valid), 32'd1);
    chk("t4_after_a", 32'(ex_a), 32'd5);

    // Not-taken BZ with r0=1
    drive(8'h80, 1, 0, 8'h01, 0); post();
    drive(8'h80, 0, 0, 0, 0); post();
    drive(8'hC4, 0, 0, 0, 0); post();
    chk("t5_pc_src", 32'(pc_src), 32'd0);
    drive(8'h80, 0, 0, 0, 0); post();
    chk("t5_bz_ex_valid", 32'(ex_valid), 32'd0);
    chk("t5_cnt", 32'(br_taken_cnt), 32'd1);
    drive(8'h80, 0, 0, 0, 0); post();
    chk("t5_no_bubble", 32'(ex_valid), 32'd1);

    // r0 written to 0 in the same cycle BZ is decoded with old r0=7
    drive(8'h80, 1, 0, 8'h07, 0); post();
    drive(8'h80, 0, 0, 0, 0); post();
    drive(8'hC4, 0, 0, 0, 0); post();
    drive(8'h80, 1, 0, 8'h00, 0);
    #1;
`ifdef DECODE_BYPASS_EN
    chk("t6_pc_src_bypass", 32'(pc_src), 32'd1);
    cnt_pre = 2;
`else
    chk("t6_pc_src_nobypass", 32'(pc_src), 32'd0);
    cnt_pre = 1;
`endif
    post();

    // 256 taken branches wrap the counter back to its starting value
    for (int k = 0; k < 512; k++) drive(8'hC0, 0, 0, 0, 0);
    drive(8'h80, 0, 0, 0, 0); post();
    chk("t6_cnt_wrap", 32'(br_taken_cnt), 32'(cnt_pre));

    // Random traffic, occasional reset
    for (int k = 0; k < 600; k++)
      drive(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            8'($urandom_range(0, 255)), ($urandom_range(0, 59) == 0));
    drive(8'h80, 0, 0, 0, 0);
    repeat (3) post();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
